// File: rtl/hc_pkg.sv
// Shared types and helpers for the Hamming SECDED decoder pipeline.
package hc_pkg;

  // Decoder classification of a received codeword
  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_CORR   = 2'b01,
    ERR_UNCORR = 2'b10,
    ERR_PAR    = 2'b11
  } err_type_e;

  // Full codeword width: data bits, Hamming check bits and the overall parity bit
  function automatic int cwWidth(input int dataWd, input int chkWd);
    return dataWd + chkWd + 1;
  endfunction

endpackage

// File: rtl/hc_syndrome.sv
// Combinational Hamming syndrome and overall-parity computation.
// Bits [N-1:0] of the codeword are Hamming positions 1..N; bit N is overall parity.
module hc_syndrome
  import hc_pkg::*;
#(
  parameter int DATA_WD = 4,
  parameter int CHK_WD  = 3
) (
  input  logic [cwWidth(DATA_WD, CHK_WD)-1:0] i_cw,
  output logic [CHK_WD-1:0]                   o_syndrome,
  output logic                                o_overall
);

  localparam int N = DATA_WD + CHK_WD;

  // Each syndrome bit covers every position whose index has that bit set
  always_comb begin
    o_syndrome = '0;
    for (int j = 1; j <= N; j++) begin
      for (int i = 0; i < CHK_WD; i++) begin
        if (((j >> i) & 1) == 1) begin
          o_syndrome[i] = o_syndrome[i] ^ i_cw[j-1];
        end
      end
    end
    o_overall = ^i_cw;
  end

endmodule

// File: rtl/hc_secded_dec_pipe.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready handshakes
// and saturating corrected/uncorrectable error counters.
module hc_secded_dec_pipe
  import hc_pkg::*;
#(
  parameter int DATA_WD = 4,
  parameter int CHK_WD  = 3,
  parameter int CNT_WD  = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic [cwWidth(DATA_WD, CHK_WD)-1:0] i_enc_data,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [DATA_WD-1:0]                  o_dec_data,
  output logic [1:0]                          o_err_type,
  input  logic                                i_cnt_clr,
  output logic [CNT_WD-1:0]                   o_corr_cnt,
  output logic [CNT_WD-1:0]                   o_uncorr_cnt
);

  localparam int N  = DATA_WD + CHK_WD;
  localparam int CW = cwWidth(DATA_WD, CHK_WD);

  // Check bits must be able to name every position plus "no error"
  generate
    if ((2 ** CHK_WD) < (N + 1)) begin : gBadParams
      $error("hc_secded_dec_pipe: CHK_WD too small for DATA_WD");
    end
  endgenerate

  logic [CHK_WD-1:0]  inSyn;
  logic               inOvr;

  logic               s1Valid_q;
  logic [CW-1:0]      s1Cw_q;
  logic [CHK_WD-1:0]  s1Syn_q;
  logic               s1Ovr_q;

  logic               oValid_q;
  logic [DATA_WD-1:0] oData_q;
  err_type_e          oErr_q;

  logic [CNT_WD-1:0]  corrCnt_q, corrCnt_d;
  logic [CNT_WD-1:0]  uncorrCnt_q, uncorrCnt_d;

  logic               load2;
  logic               adv1;
  logic               outHs;
  err_type_e          errType_d;
  logic [CW-1:0]      fixedCw;
  logic [DATA_WD-1:0] decData_d;

  hc_syndrome #(
    .DATA_WD (DATA_WD),
    .CHK_WD  (CHK_WD)
  ) uSyndrome (
    .i_cw       (i_enc_data),
    .o_syndrome (inSyn),
    .o_overall  (inOvr)
  );

  assign load2   = !oValid_q || i_ready;
  assign adv1    = load2 || !s1Valid_q;
  assign outHs   = oValid_q && i_ready;
  assign o_ready = adv1;

  // Classify the stage-1 word, apply single-bit correction and gather data bits
  always_comb begin
    int k;
    errType_d = ERR_NONE;
    fixedCw   = s1Cw_q;
    decData_d = '0;
    k         = 0;
    if (s1Syn_q == '0) begin
      errType_d = s1Ovr_q ? ERR_PAR : ERR_NONE;
    end else if (int'(s1Syn_q) > N) begin
      errType_d = ERR_UNCORR;
    end else if (s1Ovr_q) begin
      errType_d = ERR_CORR;
      fixedCw   = s1Cw_q ^ (CW'(1) << (s1Syn_q - CHK_WD'(1)));
    end else begin
      errType_d = ERR_UNCORR;
    end
    for (int j = 1; j <= N; j++) begin
      if ((j & (j - 1)) != 0) begin
        if (k < DATA_WD) begin
          decData_d[k] = fixedCw[j-1];
        end
        k++;
      end
    end
  end

  // Stage 1: capture the codeword with its syndrome whenever the stage can advance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1Valid_q <= 1'b0;
      s1Cw_q    <= '0;
      s1Syn_q   <= '0;
      s1Ovr_q   <= 1'b0;
    end else if (adv1) begin
      s1Valid_q <= i_valid;
      if (i_valid) begin
        s1Cw_q  <= i_enc_data;
        s1Syn_q <= inSyn;
        s1Ovr_q <= inOvr;
      end
    end
  end

  // Stage 2: output register, frozen while downstream stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      oValid_q <= 1'b0;
      oData_q  <= '0;
      oErr_q   <= ERR_NONE;
    end else if (load2) begin
      oValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        oData_q <= decData_d;
        oErr_q  <= errType_d;
      end
    end
  end

  // Counter next state: clear beats increment, counts saturate at all-ones
  always_comb begin
    corrCnt_d   = corrCnt_q;
    uncorrCnt_d = uncorrCnt_q;
    if (i_cnt_clr) begin
      corrCnt_d   = '0;
      uncorrCnt_d = '0;
    end else if (outHs) begin
      if ((oErr_q == ERR_CORR || oErr_q == ERR_PAR) && corrCnt_q != '1) begin
        corrCnt_d = corrCnt_q + CNT_WD'(1);
      end
      if (oErr_q == ERR_UNCORR && uncorrCnt_q != '1) begin
        uncorrCnt_d = uncorrCnt_q + CNT_WD'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      corrCnt_q   <= '0;
      uncorrCnt_q <= '0;
    end else begin
      corrCnt_q   <= corrCnt_d;
      uncorrCnt_q <= uncorrCnt_d;
    end
  end

  assign o_valid      = oValid_q;
  assign o_dec_data   = oData_q;
  assign o_err_type   = oErr_q;
  assign o_corr_cnt   = corrCnt_q;
  assign o_uncorr_cnt = uncorrCnt_q;

endmodule

// File: tb/tb_hc_secded_dec_pipe.sv
// Directed testbench for hc_secded_dec_pipe (default widths, 2-bit counters).
module tb_hc_secded_dec_pipe;

  logic       clk = 1'b0;
  logic       rstN;
  logic       iValid;
  logic       oReady;
  logic [7:0] encData;
  logic       oValid;
  logic       iReady;
  logic [3:0] decData;
  logic [1:0] errType;
  logic       cntClr;
  logic [1:0] corrCnt;
  logic [1:0] uncorrCnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] bpWord [8] = '{8'h55, 8'h45, 8'hD5, 8'h56, 8'hAA, 8'h8A, 8'h15, 8'h54};
  logic [3:0] bpData [8] = '{4'hB, 4'hB, 4'hB, 4'hB, 4'h4, 4'h4, 4'hB, 4'hB};
  logic [1:0] bpErr  [8] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01};

  always #5 clk = ~clk;

  hc_secded_dec_pipe #(
    .DATA_WD (4),
    .CHK_WD  (3),
    .CNT_WD  (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_valid      (iValid),
    .o_ready      (oReady),
    .i_enc_data   (encData),
    .o_valid      (oValid),
    .i_ready      (iReady),
    .o_dec_data   (decData),
    .o_err_type   (errType),
    .i_cnt_clr    (cntClr),
    .o_corr_cnt   (corrCnt),
    .o_uncorr_cnt (uncorrCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word, wait for it at the output, check it, then let it hand off
  task automatic applyStimulus(input string tag, input logic [7:0] w,
                               input logic [3:0] expData, input logic [1:0] expErr);
    iValid  = 1'b1;
    encData = w;
    step();
    iValid = 1'b0;
    step();
    checkOutput({tag, "_valid"}, oValid, 1);
    checkOutput({tag, "_data"}, decData, expData);
    checkOutput({tag, "_err"}, errType, expErr);
    step();
  endtask

  initial begin
    logic       acc;
    logic       hs;
    logic       stalled;
    logic [3:0] heldData;
    logic [1:0] heldErr;
    int         inIdx;
    int         outIdx;

    rstN    = 1'b0;
    iValid  = 1'b0;
    iReady  = 1'b1;
    encData = '0;
    cntClr  = 1'b0;
    step();
    step();
    checkOutput("rst_valid", oValid, 0);
    checkOutput("rst_data", decData, 0);
    checkOutput("rst_err", errType, 0);
    checkOutput("rst_corr", corrCnt, 0);
    checkOutput("rst_uncorr", uncorrCnt, 0);
    rstN = 1'b1;
    step();
    checkOutput("rel_ready", oReady, 1);

    $display("[TB] single-word decode");
    applyStimulus("clean55", 8'h55, 4'hB, 2'b00);
    checkOutput("clean55_corr", corrCnt, 0);
    checkOutput("clean55_uncorr", uncorrCnt, 0);
    applyStimulus("single45", 8'h45, 4'hB, 2'b01);
    checkOutput("single45_corr", corrCnt, 1);
    applyStimulus("parD5", 8'hD5, 4'hB, 2'b11);
    checkOutput("parD5_corr", corrCnt, 2);
    applyStimulus("double56", 8'h56, 4'hB, 2'b10);
    checkOutput("double56_uncorr", uncorrCnt, 1);
    checkOutput("double56_corr", corrCnt, 2);
    applyStimulus("cleanAA", 8'hAA, 4'h4, 2'b00);
    applyStimulus("single8A", 8'h8A, 4'h4, 2'b01);
    checkOutput("single8A_corr", corrCnt, 3);
    applyStimulus("single15", 8'h15, 4'hB, 2'b01);
    applyStimulus("single54", 8'h54, 4'hB, 2'b01);
    applyStimulus("single57", 8'h57, 4'hB, 2'b01);
    checkOutput("sat_corr", corrCnt, 3);
    checkOutput("sat_uncorr", uncorrCnt, 1);

    $display("[TB] clear during erroneous handshake");
    iValid  = 1'b1;
    encData = 8'h45;
    step();
    iValid = 1'b0;
    step();
    checkOutput("clr_err", errType, 2'b01);
    cntClr = 1'b1;
    step();
    cntClr = 1'b0;
    checkOutput("clr_corr", corrCnt, 0);
    checkOutput("clr_uncorr", uncorrCnt, 0);

    $display("[TB] backpressure stream");
    inIdx  = 0;
    outIdx = 0;
    for (int c = 0; c < 40 && outIdx < 8; c++) begin
      iReady  = !(c >= 3 && c <= 6);
      iValid  = (inIdx < 8);
      encData = (inIdx < 8) ? bpWord[inIdx] : 8'h00;
      #1;
      acc      = iValid && oReady;
      hs       = oValid && iReady;
      stalled  = oValid && !iReady;
      heldData = decData;
      heldErr  = errType;
      if (hs) begin
        checkOutput($sformatf("bp%0d_data", outIdx), decData, bpData[outIdx]);
        checkOutput($sformatf("bp%0d_err", outIdx), errType, bpErr[outIdx]);
        outIdx++;
      end
      step();
      if (acc) inIdx++;
      if (stalled) begin
        checkOutput("bp_hold_valid", oValid, 1);
        checkOutput("bp_hold_data", decData, heldData);
        checkOutput("bp_hold_err", errType, heldErr);
      end
    end
    iValid = 1'b0;
    iReady = 1'b1;
    checkOutput("bp_out_count", outIdx, 8);
    checkOutput("bp_in_count", inIdx, 8);
    checkOutput("bp_corr", corrCnt, 3);
    checkOutput("bp_uncorr", uncorrCnt, 1);

    $display("[TB] reset mid-stall");
    iValid  = 1'b1;
    encData = 8'h56;
    step();
    iValid = 1'b0;
    iReady = 1'b0;
    step();
    step();
    checkOutput("mid_valid_pre", oValid, 1);
    rstN = 1'b0;
    #1;
    checkOutput("mid_valid", oValid, 0);
    checkOutput("mid_data", decData, 0);
    checkOutput("mid_err", errType, 0);
    checkOutput("mid_corr", corrCnt, 0);
    checkOutput("mid_uncorr", uncorrCnt, 0);
    step();
    rstN   = 1'b1;
    iReady = 1'b1;
    step();
    checkOutput("mid_rel_ready", oReady, 1);
    checkOutput("mid_rel_valid", oValid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
